// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StStart,
    StData,
    StStop
  } tx_state_t;
`endif

  localparam logic LineIdle   = 1'b1;
  localparam logic StartLevel = 1'b0;

  // Baud counter width; at least one bit even for the smallest legal divider.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick pulses on the last pclk cycle of every serial bit.
// Counts only while enabled; clear has priority and restarts the bit at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic pclk,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt_q == CntMax);

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them on tx.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       pclk,
  input  logic       PRESETn,
  input  logic       uart_reset,
  input  logic [7:0] fifo_dataOut,
  input  logic       fifo_Empty,
  output logic       fifo_readEn,
  output logic       tx,
  output logic       tx_busy
);

  localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 baud_en, baud_clear, baud_tick;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // Bits above DATA_BITS are deliberately ignored.
  logic unused_data;
  assign unused_data = ^fifo_dataOut;

  assign baud_en    = !(state_q inside {StIdle, StRead, StLatch});
  assign baud_clear = (state_q == StLatch) || uart_reset;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .pclk   (pclk),
    .PRESETn(PRESETn),
    .clear  (baud_clear),
    .enable (baud_en),
    .tick   (baud_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_Empty) state_d = StRead;
      end
      StRead: begin
        state_d = StLatch;
      end
      StLatch: begin
        shift_d = fifo_dataOut[DATA_BITS-1:0];
        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
        parity_d = (^fifo_dataOut[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
        state_d = StStart;
      end
      StStart: begin
        if (baud_tick) state_d = StData;
      end
      StData: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastData) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_tick) begin
          if (idx_q == LastStop) begin
            idx_d   = '0;
            state_d = fifo_Empty ? StIdle : StRead;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (uart_reset) begin
      state_d = StIdle;
      shift_d = '0;
      idx_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = 1'b0;
`endif
    end

    // Outputs are registered, so they are derived from the next state.
    rd_en_d = (state_d == StRead);
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StStart: tx_d = StartLevel;
      StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default: tx_d = LineIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LineIdle;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign fifo_readEn = rd_en_q;
  assign tx          = tx_q;
  assign tx_busy     = busy_q;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serializer stage downstream of the UART transmit FIFO; the APB-side interface fills that FIFO.
- Pops one byte at a time from the TX FIFO and drives it on the serial line as a standard asynchronous frame: start bit, LSB-first data, optional parity, stop bit(s).
- Flow control comes only from the FIFO empty flag. There is no CPU-side handshake.

Parameters:
- CLKS_PER_BIT, 16, pclk cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8; uses fifo_dataOut[DATA_BITS-1:0].
- STOP_BITS, 1, number of stop bits; 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only meaningful when UART_TX_PARITY_EN is defined.

Ports:
- pclk  input  1  system clock
- PRESETn  input  1  reset, asynchronous, active-high; clock pclk
- uart_reset  input  1  synchronous soft reset from the APB interface; same effect as PRESETn, applied at the clock edge
- fifo_dataOut  input  8  TX FIFO read data, valid the cycle after fifo_readEn
- fifo_Empty  input  1  TX FIFO empty flag
- fifo_readEn  output  1  TX FIFO pop strobe, one-cycle pulse
- tx  output  1  serial output; idles high
- tx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset (PRESETn or uart_reset): state=IDLE, tx=1, fifo_readEn=0, tx_busy=0, baud counter=0, bit index=0, shift register=0.
- PRESETn acts immediately, including mid-frame: tx returns high at once, the partial frame is abandoned, and the FIFO byte already popped is lost.
- All outputs are registered.
- States: IDLE, READ, LATCH, START, DATA, PARITY, STOP.
- IDLE: on an edge with fifo_Empty=0 -> READ. Otherwise stay; tx=1.
- READ: fifo_readEn=1 for exactly this one cycle -> LATCH.
- LATCH: on the exiting edge, capture fifo_dataOut into the shift register, drive tx=0 -> START.
- Latency: tx falls on the 3rd edge after fifo_Empty is first sampled low in IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START, DATA, PARITY and STOP.
  - A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every bit is held exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time -> DATA.
- DATA:
  - tx = shift register bit 0; shift right at each bit end.
  - Bit index counts 0..DATA_BITS-1.
  - After the last data bit -> PARITY if the macro is defined, else -> STOP.
- STOP:
  - tx=1 for STOP_BITS bit times.
  - At the end: if fifo_Empty=0 -> READ (back-to-back frames, 2 extra idle-high cycles between frames); else -> IDLE.
- fifo_readEn is never asserted while fifo_Empty=1 and never in two consecutive cycles.
- fifo_Empty rising after READ has no effect on the frame in progress.
- Bits of fifo_dataOut above DATA_BITS are ignored.
- Frame length in cycles = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), where P=1 with parity and 0 without.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA for one bit time.
  - tx = XOR of the DATA_BITS data bits, XOR PARITY_ODD.
  - The parity bit is computed at LATCH from the captured byte.
- Undefined: the PARITY state and parity register are absent; DATA goes directly to STOP; PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum for tx_state_t;
  - localparams for the idle line level (1) and start bit level (0);
  - a function for the counter width, clog2(CLKS_PER_BIT).
- One sub-module: uart_baud_tick.
  - Parameter CLKS_PER_BIT.
  - Inputs: pclk, PRESETn, clear, enable.
  - Output: tick, a one-cycle pulse at the last cycle of each bit.
  - The engine asserts clear on the LATCH edge.
- The FSM, shift register and bit counter stay in uart_tx_engine.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0xA5, parity off -> one fifo_readEn pulse; tx sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high for 40+2 cycles; return to IDLE.
- Three bytes 0x00, 0xFF, 0x55 preloaded -> exactly 3 readEn pulses, each separated by 3+40-1 cycles; exactly 2 idle-high cycles between frames; bits correct.
- UART_TX_PARITY_EN, PARITY_ODD=0, data 0x07 -> parity bit=1. With PARITY_ODD=1 -> parity bit=0. Frame is 11 bit times.
- PRESETn pulsed during the 4th data bit of 0x3C -> tx=1 immediately, state IDLE, no readEn while reset is held; next FIFO byte is sent cleanly after release.
- uart_reset held high for 1 cycle during START -> tx=1 on the next edge; fifo_Empty=1 throughout -> tx stays 1 and no readEn ever.
- STOP_BITS=2, DATA_BITS=7, data 0xFF -> bit 7 is not transmitted; stop high for 2*CLKS_PER_BIT cycles.
